// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: shared types for the framebuffer scanout block.
//   state_t   - scanout controller states
//   pix_src_t - where the output pixel of a pipeline slot comes from
//   rgb565_t  - 16-bit RGB565 pixel
package fb_scanout_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BORDER_COLOR_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    READY,
    ACTIVE,
    DONE,
    BLANKED
  } state_t;

  typedef enum logic [1:0] {
    PIX_ZERO,    // outside display data enable
    PIX_BORDER,  // border / blanked colour
    PIX_STREAM,  // fresh stream pixel or its horizontal replica
    PIX_LBUF     // replicated line, read back from the line buffer
  } pix_src_t;

endpackage

// File: rtl/fb_line_buffer.sv
// fb_line_buffer: one framebuffer line of RGB565 pixels.
//   clk     - clock
//   wr_en   - write strobe, wr_addr / wr_data
//   rd_en   - read strobe, rd_addr; rd_data valid one cycle later
// Contents are never cleared so the array maps onto block RAM.
module fb_line_buffer
  import fb_scanout_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rgb565_t       wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output rgb565_t       rd_data
);

  rgb565_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: scales a FB_WIDTH x FB_HEIGHT pixel stream into a window of the
// display raster by pixel/line replication.
//   clk_pix, reset_i            - pixel clock, synchronous active-high reset
//   enable_i, frame_start_i     - frame control (enable sampled at frame start)
//   hpos_i, vpos_i, de_i, sync_i- incoming raster timing
//   stream_*                    - framebuffer stream handshake and status
//   rgb_o, de_o, sync_o         - output pixel and timing, 2 cycles after input
//   err_underflow_o, err_late_o - sticky error flags
// Pipeline: stage 0 decodes position and FSM, stage 1 holds stream_ena_o and
// the line-buffer read, stage 2 selects the final pixel.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int      FB_WIDTH     = 128,
  parameter int      FB_HEIGHT    = 128,
  parameter int      H_SCALE      = 3,
  parameter int      V_SCALE      = 3,
  parameter int      H_OFFSET     = 128,
  parameter int      V_OFFSET     = 48,
  parameter rgb565_t BORDER_COLOR = BORDER_COLOR_DEFAULT
) (
  input  logic        clk_pix,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        frame_start_i,
  input  logic [10:0] hpos_i,
  input  logic [10:0] vpos_i,
  input  logic        de_i,
  input  logic [1:0]  sync_i,
  output logic        stream_start_frame_o,
  output logic        stream_ena_o,
  input  logic [15:0] stream_data_i,
  input  logic        stream_preloading_i,
  input  logic        stream_err_underflow_i,
  output logic [15:0] rgb_o,
  output logic        de_o,
  output logic [1:0]  sync_o,
  output logic        err_underflow_o,
  output logic        err_late_o
);

  localparam int AW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam int HW = $clog2(H_SCALE);
  localparam int VW = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic [11:0]   H_START = 12'(H_OFFSET);
  localparam logic [11:0]   H_END   = 12'(H_OFFSET + FB_WIDTH * H_SCALE);
  localparam logic [11:0]   V_START = 12'(V_OFFSET);
  localparam logic [11:0]   V_END   = 12'(V_OFFSET + FB_HEIGHT * V_SCALE);
  localparam logic [AW-1:0] X_LAST  = AW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FB_HEIGHT - 1);
  localparam logic [HW-1:0] HS_LAST = HW'(H_SCALE - 1);
  localparam logic [VW-1:0] VS_LAST = VW'(V_SCALE - 1);

  state_t        state_reg, state_next;
  logic          preload_cnt_reg, preload_cnt_next;
  logic [HW-1:0] h_sub_reg, h_sub_next, cur_h_sub;
  logic [AW-1:0] fb_x_reg, fb_x_next, cur_fb_x;
  logic [VW-1:0] v_sub_reg, v_sub_next;
  logic [YW-1:0] fb_y_reg, fb_y_next;

  logic     win, first_col, line_last, frame_last;
  logic     act, late_set, start_next, ena_next, lb_rd_en;
  pix_src_t src_next, src_reg;
  logic [AW-1:0] wr_addr_reg;
  logic     de_reg;
  logic [1:0] sync_reg;
  rgb565_t  hold_reg, lb_rd_data, rgb_next;

  assign win = de_i
            && ({1'b0, hpos_i} >= H_START) && ({1'b0, hpos_i} < H_END)
            && ({1'b0, vpos_i} >= V_START) && ({1'b0, vpos_i} < V_END);
  assign first_col = ({1'b0, hpos_i} == H_START);

  // The horizontal counters restart on every line's first window pixel, so
  // the current position is forced to zero there rather than taken from the
  // registers left over from the previous line.
  assign cur_h_sub  = first_col ? '0 : h_sub_reg;
  assign cur_fb_x   = first_col ? '0 : fb_x_reg;
  assign line_last  = (cur_fb_x == X_LAST) && (cur_h_sub == HS_LAST);
  assign frame_last = line_last && (v_sub_reg == VS_LAST) && (fb_y_reg == Y_LAST);

  // Position counters
  always_comb begin
    h_sub_next = h_sub_reg;
    fb_x_next  = fb_x_reg;
    v_sub_next = v_sub_reg;
    fb_y_next  = fb_y_reg;
    if (frame_start_i) begin
      h_sub_next = '0;
      fb_x_next  = '0;
      v_sub_next = '0;
      fb_y_next  = '0;
    end else if (win) begin
      if (cur_h_sub == HS_LAST) begin
        h_sub_next = '0;
        fb_x_next  = (cur_fb_x == X_LAST) ? '0 : cur_fb_x + 1'b1;
      end else begin
        h_sub_next = cur_h_sub + 1'b1;
        fb_x_next  = cur_fb_x;
      end
      if (line_last) begin
        if (v_sub_reg == VS_LAST) begin
          v_sub_next = '0;
          fb_y_next  = (fb_y_reg == Y_LAST) ? '0 : fb_y_reg + 1'b1;
        end else begin
          v_sub_next = v_sub_reg + 1'b1;
        end
      end
    end
  end

  // Controller next state; act marks a window pixel that shows image data.
  always_comb begin
    state_next       = state_reg;
    preload_cnt_next = preload_cnt_reg;
    start_next       = 1'b0;
    late_set         = 1'b0;
    act              = 1'b0;
    if (frame_start_i) begin
      preload_cnt_next = 1'b0;
      if (enable_i) begin
        state_next = PRELOAD;
        start_next = 1'b1;
      end else begin
        state_next = BLANKED;
      end
    end else begin
      case (state_reg)
        PRELOAD: begin
          if (win) begin
            late_set   = 1'b1;
            state_next = BLANKED;
          end else begin
            // preload_cnt_reg set means at least one PRELOAD cycle has passed
            preload_cnt_next = 1'b1;
            if (preload_cnt_reg && !stream_preloading_i) begin
              state_next = READY;
            end
          end
        end
        READY: begin
          if (win) begin
            act        = 1'b1;
            state_next = frame_last ? DONE : ACTIVE;
          end
        end
        ACTIVE: begin
          if (win) begin
            act = 1'b1;
            if (frame_last) begin
              state_next = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ena_next = act && (v_sub_reg == '0) && (cur_h_sub == '0);
  assign lb_rd_en = act && (v_sub_reg != '0);

  always_comb begin
    src_next = PIX_BORDER;
    if (!de_i) begin
      src_next = PIX_ZERO;
    end else if (act) begin
      src_next = (v_sub_reg == '0) ? PIX_STREAM : PIX_LBUF;
    end
  end

  always_comb begin
    rgb_next = '0;
    case (src_reg)
      PIX_BORDER: rgb_next = BORDER_COLOR;
      PIX_STREAM: rgb_next = stream_ena_o ? stream_data_i : hold_reg;
      PIX_LBUF:   rgb_next = lb_rd_data;
      default:    rgb_next = '0;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset_i) begin
      state_reg       <= IDLE;
      preload_cnt_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      preload_cnt_reg <= preload_cnt_next;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset_i) begin
      h_sub_reg            <= '0;
      fb_x_reg             <= '0;
      v_sub_reg            <= '0;
      fb_y_reg             <= '0;
      stream_start_frame_o <= 1'b0;
      stream_ena_o         <= 1'b0;
      wr_addr_reg          <= '0;
      src_reg              <= PIX_ZERO;
      de_reg               <= 1'b0;
      sync_reg             <= '0;
      hold_reg             <= '0;
      rgb_o                <= '0;
      de_o                 <= 1'b0;
      sync_o               <= '0;
      err_underflow_o      <= 1'b0;
      err_late_o           <= 1'b0;
    end else begin
      h_sub_reg            <= h_sub_next;
      fb_x_reg             <= fb_x_next;
      v_sub_reg            <= v_sub_next;
      fb_y_reg             <= fb_y_next;
      stream_start_frame_o <= start_next;
      stream_ena_o         <= ena_next;
      wr_addr_reg          <= cur_fb_x;
      src_reg              <= src_next;
      de_reg               <= de_i;
      sync_reg             <= sync_i;
      if (stream_ena_o) begin
        hold_reg <= stream_data_i;
      end
      rgb_o                <= rgb_next;
      de_o                 <= de_reg;
      sync_o               <= sync_reg;
      err_underflow_o      <= err_underflow_o | stream_err_underflow_i;
      err_late_o           <= err_late_o | late_set;
    end
  end

  fb_line_buffer #(
    .DEPTH (FB_WIDTH),
    .AW    (AW)
  ) u_line_buffer (
    .clk     (clk_pix),
    .wr_en   (stream_ena_o),
    .wr_addr (wr_addr_reg),
    .wr_data (stream_data_i),
    .rd_en   (lb_rd_en),
    .rd_addr (cur_fb_x),
    .rd_data (lb_rd_data)
  );

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: drives a small raster (56x24 total, 48x20 active) into two
// scanout instances (A: 3x2 scaling with a visible border colour, B: 2x1
// scaling with the default border) and compares every output cycle against a
// coordinate-based model of the scaled image.
module tb_fb_scanout;
  import fb_scanout_pkg::*;

  localparam int HT = 56, VT = 24, HA = 48, VA = 20;
  localparam int FBW = 8, FBH = 6, HO = 10, VO = 4;
  localparam logic [15:0] BORDER_A = 16'h07E0;
  localparam logic [15:0] BORDER_B = 16'h0000;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic        reset_i, enable_i, frame_start_i, de_i;
  logic [10:0] hpos_i, vpos_i;
  logic [1:0]  sync_i;
  logic        stream_preloading_i, stream_err_underflow_i;

  logic        start_a, ena_a, de_a, uf_a, late_a;
  logic        start_b, ena_b, de_b, uf_b, late_b;
  logic [15:0] data_a, data_b, rgb_a, rgb_b;
  logic [1:0]  sync_a, sync_b;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] img(int x, int y);
    return 16'(32'h1000 + y * 256 + x);
  endfunction

  // Expected display pixel from raster coordinates alone.
  function automatic logic [15:0] model_rgb(bit normal, bit de, int x, int y,
                                            int hs, int vs, logic [15:0] border);
    if (!de) return 16'h0000;
    if (normal && x >= HO && x < HO + FBW * hs && y >= VO && y < VO + FBH * vs)
      return img((x - HO) / hs, (y - VO) / vs);
    return border;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  fb_scanout #(
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .H_SCALE(3), .V_SCALE(2),
    .H_OFFSET(HO), .V_OFFSET(VO), .BORDER_COLOR(BORDER_A)
  ) dut_a (
    .clk_pix(clk_pix), .reset_i(reset_i), .enable_i(enable_i),
    .frame_start_i(frame_start_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
    .de_i(de_i), .sync_i(sync_i), .stream_start_frame_o(start_a),
    .stream_ena_o(ena_a), .stream_data_i(data_a),
    .stream_preloading_i(stream_preloading_i),
    .stream_err_underflow_i(stream_err_underflow_i),
    .rgb_o(rgb_a), .de_o(de_a), .sync_o(sync_a),
    .err_underflow_o(uf_a), .err_late_o(late_a)
  );

  fb_scanout #(
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .H_SCALE(2), .V_SCALE(1),
    .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut_b (
    .clk_pix(clk_pix), .reset_i(reset_i), .enable_i(enable_i),
    .frame_start_i(frame_start_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
    .de_i(de_i), .sync_i(sync_i), .stream_start_frame_o(start_b),
    .stream_ena_o(ena_b), .stream_data_i(data_b),
    .stream_preloading_i(stream_preloading_i),
    .stream_err_underflow_i(stream_err_underflow_i),
    .rgb_o(rgb_b), .de_o(de_b), .sync_o(sync_b),
    .err_underflow_o(uf_b), .err_late_o(late_b)
  );

  // Framebuffer stream sources: row-major ramp, restarted by each frame pulse.
  int idx_a = 0, idx_b = 0;
  always @(posedge clk_pix) begin
    if (start_a) idx_a <= 0; else if (ena_a) idx_a <= idx_a + 1;
    if (start_b) idx_b <= 0; else if (ena_b) idx_b <= idx_b + 1;
  end
  assign data_a = img(idx_a % FBW, idx_a / FBW);
  assign data_b = img(idx_b % FBW, idx_b / FBW);

  // Two-deep expectation pipeline mirroring the fixed output latency.
  typedef struct {
    logic [15:0] rgb_a;
    logic [15:0] rgb_b;
    logic        de;
    logic [1:0]  sync;
    int          x;
    int          y;
    bit          normal;
  } exp_t;

  exp_t e1, e2;
  bit   model_normal = 1'b0;
  bit   cmp_en = 1'b0;
  bit   rst_seen = 1'b0;

  always @(posedge clk_pix) begin
    rst_seen = reset_i;
    if (reset_i) begin
      e1 = '{default: 0};
      e2 = '{default: 0};
    end else begin
      e2 = e1;
      e1.rgb_a  = model_rgb(model_normal, de_i, int'(hpos_i), int'(vpos_i), 3, 2, BORDER_A);
      e1.rgb_b  = model_rgb(model_normal, de_i, int'(hpos_i), int'(vpos_i), 2, 1, BORDER_B);
      e1.de     = de_i;
      e1.sync   = sync_i;
      e1.x      = int'(hpos_i);
      e1.y      = int'(vpos_i);
      e1.normal = model_normal;
    end
  end

  int cnt_a, cnt_b, starts_a, starts_b;
  bit prev_ena_a = 1'b0, prev_ena_b = 1'b0;

  always @(negedge clk_pix) begin
    if (cmp_en) begin
      chk("rgb_a", rgb_a, e2.rgb_a);
      chk("de_a", de_a, e2.de);
      chk("sync_a", sync_a, e2.sync);
      chk("rgb_b", rgb_b, e2.rgb_b);
      chk("de_b", de_b, e2.de);
      chk("sync_b", sync_b, e2.sync);
      chk("lbuf_read_b", dut_b.lb_rd_en, 0);
      if (e2.normal && e2.x == 10 && e2.y == 4)  chk("pin_a_first", rgb_a, 16'h1000);
      if (e2.normal && e2.x == 33 && e2.y == 15) chk("pin_a_last", rgb_a, 16'h1507);
      if (e2.normal && e2.x == 25 && e2.y == 9)  chk("pin_b_last", rgb_b, 16'h1507);
      if (rst_seen) begin
        chk("rst_rgb_a", rgb_a, 0);
        chk("rst_ena_a", ena_a, 0);
        chk("rst_start_a", start_a, 0);
        chk("rst_uf_a", uf_a, 0);
        chk("rst_state_a", 32'(dut_a.state_reg), 32'(IDLE));
        chk("rst_state_b", 32'(dut_b.state_reg), 32'(IDLE));
      end
      if (ena_a) begin chk("ena_gap_a", prev_ena_a, 0); cnt_a++; end
      if (ena_b) begin chk("ena_gap_b", prev_ena_b, 0); cnt_b++; end
      if (start_a) starts_a++;
      if (start_b) starts_b++;
      prev_ena_a = ena_a;
      prev_ena_b = ena_b;
    end
  end

  // One frame: a vblank line carrying frame_start, then lines 0..VT-2.
  task automatic run_frame(input bit en, input bit late, input int rst_line,
                           input int uf_line, input int exp_ena,
                           input bit exp_uf, input bit exp_late);
    int v;
    int cyc;
    cnt_a = 0; cnt_b = 0; starts_a = 0; starts_b = 0;
    for (int li = 0; li < VT; li++) begin
      v = (li == 0) ? VT - 1 : li - 1;
      for (int h = 0; h < HT; h++) begin
        cyc = li * HT + h;
        hpos_i = 11'(h);
        vpos_i = 11'(v);
        de_i   = (h < HA) && (v < VA);
        sync_i = {(v >= 21 && v < 23), (h >= 50 && h < 54)};
        frame_start_i = (cyc == 0);
        enable_i = (cyc == 0) ? en : !en;
        stream_preloading_i = late ? 1'b1 : (cyc < 5);
        stream_err_underflow_i = (v == uf_line) && (h == 5);
        reset_i = (v == rst_line) && (h == 20);
        if (cyc == 0) model_normal = en && !late;
        if (reset_i) model_normal = 1'b0;
        @(posedge clk_pix);
        #1;
      end
    end
    if (exp_ena >= 0) begin
      chk("ena_count_a", cnt_a, exp_ena);
      chk("ena_count_b", cnt_b, exp_ena);
    end
    chk("start_count_a", starts_a, en);
    chk("start_count_b", starts_b, en);
    chk("err_underflow_a", uf_a, exp_uf);
    chk("err_underflow_b", uf_b, exp_uf);
    chk("err_late_a", late_a, exp_late);
    chk("err_late_b", late_b, exp_late);
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; frame_start_i = 1'b0; de_i = 1'b0;
    hpos_i = '0; vpos_i = '0; sync_i = '0;
    stream_preloading_i = 1'b0; stream_err_underflow_i = 1'b0;

    // Hand-computed points that pin the model itself.
    chk("model_a_origin", model_rgb(1, 1, 10, 4, 3, 2, BORDER_A), 16'h1000);
    chk("model_a_x1", model_rgb(1, 1, 13, 5, 3, 2, BORDER_A), 16'h1001);
    chk("model_a_corner", model_rgb(1, 1, 33, 15, 3, 2, BORDER_A), 16'h1507);
    chk("model_a_right", model_rgb(1, 1, 34, 4, 3, 2, BORDER_A), 16'h07E0);
    chk("model_a_nde", model_rgb(1, 0, 20, 4, 3, 2, BORDER_A), 16'h0000);
    chk("model_b_corner", model_rgb(1, 1, 25, 9, 2, 1, BORDER_B), 16'h1507);
    chk("model_b_right", model_rgb(1, 1, 26, 9, 2, 1, BORDER_B), 16'h0000);

    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("reset_rgb_a", rgb_a, 0);
    chk("reset_de_a", de_a, 0);
    chk("reset_sync_a", sync_a, 0);
    chk("reset_ena_a", ena_a, 0);
    chk("reset_start_a", start_a, 0);
    chk("reset_errs_a", {uf_a, late_a}, 0);
    chk("reset_errs_b", {uf_b, late_b}, 0);
    reset_i = 1'b0;
    @(posedge clk_pix);
    #1;
    cmp_en = 1'b1;

    run_frame(1, 0, -1, -1, FBW * FBH, 0, 0);  // normal image
    run_frame(1, 0, -1,  8, FBW * FBH, 1, 0);  // underflow pulse mid-frame
    run_frame(0, 0, -1, -1, 0,         1, 0);  // disabled: border only
    run_frame(1, 1, -1, -1, 0,         1, 1);  // preload never finishes
    run_frame(1, 0, -1, -1, FBW * FBH, 1, 1);  // recovers, flags stay sticky
    run_frame(1, 0, 10, -1, -1,        0, 0);  // reset mid-window clears all
    run_frame(1, 0, -1, -1, FBW * FBH, 0, 0);  // complete frame after reset

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Param FB_WIDTH, default 128, framebuffer pixels per line.
REQ-002 Param FB_HEIGHT, default 128, framebuffer lines.
REQ-003 Param H_SCALE, default 3, horizontal replication factor (>=2).
REQ-004 Param V_SCALE, default 3, vertical replication factor (>=1).
REQ-005 Param H_OFFSET, default 128, first window column (display coords).
REQ-006 Param V_OFFSET, default 48, first window line (display coords).
REQ-007 Param BORDER_COLOR, default 16'h0000, RGB565 outside window or blanked.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 clk_pix  in  1  pixel clock.
REQ-010 reset_i  in  1  synchronous active-high reset.
REQ-011 enable_i  in  1  scanout enable, sampled only at frame_start_i.
REQ-012 frame_start_i  in  1  one-cycle pulse, vertical blanking, before line V_OFFSET.
REQ-013 hpos_i  in  11  display column.
REQ-014 vpos_i  in  11  display line.
REQ-015 de_i  in  1  display data enable.
REQ-016 sync_i  in  2  {vsync, hsync} passthrough.
REQ-017 stream_start_frame_o  out  1  framebuffer frame restart pulse.
REQ-018 stream_ena_o  out  1  consume one stream pixel.
REQ-019 stream_data_i  in  16  current stream pixel, valid in cycle stream_ena_o high.
REQ-020 stream_preloading_i  in  1  framebuffer preload busy.
REQ-021 stream_err_underflow_i  in  1  framebuffer underflow pulse.
REQ-022 rgb_o  out  16  RGB565 pixel.
REQ-023 de_o  out  1  delayed de_i.
REQ-024 sync_o  out  2  delayed sync_i.
REQ-025 err_underflow_o  out  1  sticky, set by stream_err_underflow_i.
REQ-026 err_late_o  out  1  sticky, preload not finished at first window pixel.

Function
REQ-027 rgb_o, de_o, sync_o: fixed 2-cycle latency from hpos_i/vpos_i/de_i/sync_i.
REQ-028 Window: de_i && hpos in [H_OFFSET, H_OFFSET+FB_WIDTH*H_SCALE) && vpos in [V_OFFSET, V_OFFSET+FB_HEIGHT*V_SCALE); outside -> BORDER_COLOR when de, 0 when !de.
REQ-029 Coordinates via counters only (h_sub 0..H_SCALE-1, fb_x, v_sub 0..V_SCALE-1, fb_y); no dividers; h counters reset at each line's first window pixel.
REQ-030 FSM states IDLE, PRELOAD, READY, ACTIVE, DONE, BLANKED.
REQ-031 frame_start_i in any state: enable_i=1 -> stream_start_frame_o high next cycle, go PRELOAD; enable_i=0 -> go BLANKED.
REQ-032 PRELOAD: stay >=2 cycles and while stream_preloading_i=1; then READY.
REQ-033 First window pixel in READY -> ACTIVE; in PRELOAD -> set err_late_o, go BLANKED (border all frame, no stream_ena_o).
REQ-034 ACTIVE, v_sub==0 line: stream_ena_o=1 when h_sub==0; stream_data_i captured, written to line buffer at fb_x, replicated H_SCALE pixels.
REQ-035 ACTIVE, v_sub!=0 line: no stream_ena_o; pixel read from line buffer at fb_x.
REQ-036 Exactly FB_WIDTH*FB_HEIGHT stream_ena_o pulses per ACTIVE frame; never two consecutive cycles.
REQ-037 After last window pixel (fb_x=FB_WIDTH-1, fb_y=FB_HEIGHT-1, last sub-pixel) -> DONE; DONE/BLANKED/IDLE output border in window.
REQ-038 frame_start_i coinciding with window pixel: frame_start wins; that pixel is border.
REQ-039 Sticky errors clear only on reset.

Reset
REQ-040 reset_i: state IDLE, all counters 0, all outputs 0 including stream_start_frame_o, stream_ena_o, errors; line buffer contents undefined, not cleared; reset mid-frame takes effect next cycle.

Structure
REQ-041 Package fb_scanout_pkg: FSM state enum, RGB565 typedef, BORDER_COLOR default constant.
REQ-042 Sub-module fb_line_buffer: FB_WIDTHx16, one write port, one read port, 1-cycle registered read.

Verification
REQ-043 640x480 timing, 128x128 ramp image, scale 3: every window pixel equals fb[(y-48)/3][(x-128)/3]; 16384 stream_ena_o per frame.
REQ-044 frame_start_i with stream_preloading_i held high past line 48 -> err_late_o=1, window all 16'h0000, zero stream_ena_o.
REQ-045 enable_i=0 at frame_start_i -> no stream_start_frame_o, border-only frame; next frame enabled -> normal image.
REQ-046 stream_err_underflow_i pulse mid-frame -> err_underflow_o=1 until reset_i.
REQ-047 reset_i asserted at fb_y=40 -> next cycle all outputs 0, state IDLE; next frame_start_i -> complete correct frame.
REQ-048 V_SCALE=1, H_SCALE=2 -> stream_ena_o every 2nd window cycle, line buffer never read.
